wb_spi1_seq: RTL and testbench

- Byte-stream sequencer directly upstream of the SPI1 master peripheral.
- CPU pushes bytes into a TX FIFO through a Wishbone slave port.
- A Wishbone master port drives the SPI1 register map for each byte: write CS, write DATA, poll STATUS until idle, read DATA.
- Received bytes land in an RX FIFO, so the CPU never polls per byte.

---
 rtl/wb_spi1_pkg.sv | 34 +++
 rtl/wb_spi1_seq_if.sv | 14 +
 rtl/spi_byte_fifo.sv | 59 +++++
 rtl/wb_spi1_seq.sv | 189 ++++++++++++++++++
 tb/tb_wb_spi1_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_spi1_pkg.sv
// Shared definitions for the SPI1 byte sequencer: register offsets, STATUS
// bit positions and sequencer state encoding.
package wb_spi1_pkg;

  // Slave register select, taken from s_adr_i[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  // SPI1 register offsets on the master port
  localparam logic [31:0] SPI_DATA   = 32'h0;
  localparam logic [31:0] SPI_STATUS = 32'h4;
  localparam logic [31:0] SPI_CS     = 32'h8;
  localparam logic [31:0] SPI_DIV    = 32'hC;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TX_FULL = 1;
  localparam int unsigned ST_TX_EMPT = 2;
  localparam int unsigned ST_RX_FULL = 3;
  localparam int unsigned ST_RX_EMPT = 4;
  localparam int unsigned ST_RX_OVF  = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIV_WR  = 3'd1,
    S_CS_WR   = 3'd2,
    S_DATA_WR = 3'd3,
    S_POLL    = 3'd4,
    S_RD      = 3'd5,
    S_PUSH    = 3'd6
  } state_e;

endpackage

// File: rtl/wb_spi1_seq_if.sv
// Classic Wishbone bus bundle; dat_w flows master->slave, dat_r slave->master.
interface wb_spi1_seq_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack);
  modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/spi_byte_fifo.sv
// Synchronous 8-bit FIFO with fall-through head; a push into a full FIFO is
// accepted when a pop happens on the same cycle.
module spi_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop & (level_q != '0);
    do_push  = push & ((level_q != FULL_LVL) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/wb_spi1_seq.sv
// CPU-facing byte sequencer: TX/RX FIFOs behind a Wishbone slave, and a
// Wishbone master that runs CS/DATA/poll/read on SPI1 for every TX byte.
module wb_spi1_seq
  import wb_spi1_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] SPI_BASE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_spi1_seq_if.slave         s_bus,
  wb_spi1_seq_if.master        m_bus,
  output logic                 irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_dout, rx_dout;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_push, tx_pop, rx_push, rx_pop;

  logic          s_ack_q, s_ack_d;
  logic [31:0]   s_dat_q, s_dat_d;
  logic [9:0]    ctrl_q, ctrl_d;
  logic [7:0]    div_q, div_d;
  logic          div_pending_q, div_pending_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  state_e        state_q, state_d;
  logic          cyc_q, cyc_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d, wdat_q, wdat_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  logic          req, first, wr_en, rd_en, busy, div_clr, ovf_set;
  logic [1:0]    reg_sel;
  logic [31:0]   status;
  logic          unused_ok;

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .din(s_bus.dat_w[7:0]), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_byte_q), .pop(rx_pop),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign busy = (state_q != S_IDLE);

  always_comb begin
    status                = '0;
    status[ST_BUSY]       = busy;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPT]    = tx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_EMPT]    = rx_empty;
    status[ST_RX_OVF]     = ovf_q;
    status[15:8]          = 8'(tx_level);
    status[23:16]         = 8'(rx_level);
  end

  // Slave side: an access acts only on the cycle before ack rises.
  always_comb begin
    req     = s_bus.cyc & s_bus.stb;
    first   = req & ~s_ack_q;
    wr_en   = first & s_bus.we;
    rd_en   = first & ~s_bus.we;
    reg_sel = s_bus.adr[3:2];
    tx_push = wr_en && (reg_sel == REG_DATA);
    rx_pop  = rd_en && (reg_sel == REG_DATA) && !rx_empty;
    s_ack_d = req;
    s_dat_d = s_dat_q;
    if (first) begin
      s_dat_d = '0;
      if (!s_bus.we) begin
        case (reg_sel)
          REG_DATA:   s_dat_d = rx_empty ? '0 : {24'h0, rx_dout};
          REG_STATUS: s_dat_d = status;
          REG_CTRL:   s_dat_d = {22'h0, ctrl_q};
          REG_DIV:    s_dat_d = {24'h0, div_q};
        endcase
      end
    end
    ctrl_d        = (wr_en && reg_sel == REG_CTRL) ? s_bus.dat_w[9:0] : ctrl_q;
    div_d         = (wr_en && reg_sel == REG_DIV)  ? s_bus.dat_w[7:0] : div_q;
    div_pending_d = div_pending_q;
    if (div_clr) div_pending_d = 1'b0;
    if (wr_en && reg_sel == REG_DIV) div_pending_d = 1'b1;
    ovf_d = ovf_q;
    if (wr_en && reg_sel == REG_STATUS && s_bus.dat_w[ST_RX_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    irq_d = ctrl_q[9] & ((tx_empty & ~busy) | ovf_q);
  end

  // Bus states launch an op whenever cyc is low, so the cycle after each ack
  // is the mandatory idle cycle and POLL re-reads simply by staying put.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rx_byte_d = rx_byte_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    div_clr   = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_pending_q)                state_d = S_DIV_WR;
        else if (ctrl_q[8] && !tx_empty)  state_d = S_CS_WR;
      end
      S_PUSH: begin
        rx_push = 1'b1;
        ovf_set = rx_full & ~rx_pop;
        state_d = S_IDLE;
      end
      default: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          wdat_d = '0;
          case (state_q)
            S_DIV_WR:  begin we_d = 1'b1; adr_d = SPI_BASE + SPI_DIV;    wdat_d = {24'h0, div_q}; end
            S_CS_WR:   begin we_d = 1'b1; adr_d = SPI_BASE + SPI_CS;     wdat_d = {24'h0, ctrl_q[7:0]}; end
            S_DATA_WR: begin we_d = 1'b1; adr_d = SPI_BASE + SPI_DATA;   wdat_d = {24'h0, tx_dout}; tx_pop = 1'b1; end
            S_POLL:    begin we_d = 1'b0; adr_d = SPI_BASE + SPI_STATUS; end
            default:   begin we_d = 1'b0; adr_d = SPI_BASE + SPI_DATA;   end
          endcase
        end else if (m_bus.ack) begin
          cyc_d = 1'b0;
          case (state_q)
            S_DIV_WR:  begin div_clr = 1'b1; state_d = S_IDLE; end
            S_CS_WR:   state_d = S_DATA_WR;
            S_DATA_WR: state_d = S_POLL;
            S_POLL:    if (!m_bus.dat_r[0]) state_d = S_RD;
            default:   begin rx_byte_d = m_bus.dat_r[7:0]; state_d = S_PUSH; end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ack_q       <= 1'b0;
      s_dat_q       <= '0;
      ctrl_q        <= '0;
      div_q         <= '0;
      div_pending_q <= 1'b0;
      ovf_q         <= 1'b0;
      irq_q         <= 1'b0;
      state_q       <= S_IDLE;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      wdat_q        <= '0;
      rx_byte_q     <= '0;
    end else begin
      s_ack_q       <= s_ack_d;
      s_dat_q       <= s_dat_d;
      ctrl_q        <= ctrl_d;
      div_q         <= div_d;
      div_pending_q <= div_pending_d;
      ovf_q         <= ovf_d;
      irq_q         <= irq_d;
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      wdat_q        <= wdat_d;
      rx_byte_q     <= rx_byte_d;
    end
  end

  assign s_bus.ack   = s_ack_q;
  assign s_bus.dat_r = s_dat_q;
  assign m_bus.cyc   = cyc_q;
  assign m_bus.stb   = cyc_q;
  assign m_bus.we    = we_q;
  assign m_bus.adr   = adr_q;
  assign m_bus.dat_w = wdat_q;
  assign m_bus.sel   = 4'hF;
  assign irq         = irq_q;

  assign unused_ok = ^{s_bus.sel, s_bus.adr[31:4], s_bus.adr[1:0], s_bus.dat_w[31:10], m_bus.dat_r[31:8]};

endmodule

// File: tb/tb_wb_spi1_seq.sv
// Bench for wb_spi1_seq: CPU-side Wishbone tasks, an SPI1 register model on
// the master port, and a scoreboard of expected master operations.
module tb_wb_spi1_seq;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;

  wb_spi1_seq_if s_bus ();
  wb_spi1_seq_if m_bus ();

  wb_spi1_seq #(.FIFO_DEPTH(DEPTH), .SPI_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .s_bus(s_bus), .m_bus(m_bus), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } op_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  op_t  exp_q[$];
  op_t  obs_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_total = 0;
  int   obs_cnt = 0;
  logic irq_seen = 1'b0;

  // SPI1 model: transfer result is MOSI ^ 8'h99, busy for two status polls
  logic [7:0]  shreg;
  int unsigned polls_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bus.ack   <= 1'b0;
      m_bus.dat_r <= '0;
      shreg       <= '0;
      polls_left  <= 0;
    end else begin
      m_bus.ack <= 1'b0;
      if (m_bus.cyc && m_bus.stb && !m_bus.ack) begin
        m_bus.ack <= 1'b1;
        obs_q.push_back(op_t'{we: m_bus.we, adr: m_bus.adr,
                              dat: (m_bus.we ? m_bus.dat_w : 32'h0), sel: m_bus.sel});
        obs_cnt <= obs_cnt + 1;
        if (m_bus.we && m_bus.adr == BASE + 32'h0) begin
          shreg      <= m_bus.dat_w[7:0] ^ 8'h99;
          polls_left <= 2;
        end
        if (!m_bus.we && m_bus.adr == BASE + 32'h4) begin
          m_bus.dat_r <= {31'h0, polls_left != 0};
          if (polls_left != 0) polls_left <= polls_left - 1;
        end else if (!m_bus.we && m_bus.adr == BASE + 32'h0) begin
          m_bus.dat_r <= {24'h0, shreg};
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cpu(input logic we, input logic [3:0] off, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd);
    logic got;
    @(posedge clk); #1;
    s_bus.adr   = {28'h0, off};
    s_bus.dat_w = wd;
    s_bus.we    = we;
    s_bus.sel   = 4'hF;
    s_bus.cyc   = 1'b1;
    s_bus.stb   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = s_bus.ack;
    end
    rd = s_bus.dat_r;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL cpu_ack: got no ack want ack within 8 cycles (off %h)", off);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("ack_held", {31'h0, s_bus.ack}, 32'h1);
    end
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    s_bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    logic [31:0] r;
    cpu(1'b1, off, d, 0, r);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    cpu(1'b0, off, 32'h0, 0, r);
    chk(name, r, exp);
  endtask

  task automatic exp_op(input logic we, input logic [3:0] off, input logic [31:0] d);
    exp_q.push_back(op_t'{we: we, adr: BASE + {28'h0, off}, dat: d, sel: 4'hF});
    exp_total++;
  endtask

  task automatic exp_byte(input logic [7:0] cs, input logic [7:0] b);
    exp_op(1'b1, 4'h8, {24'h0, cs});
    exp_op(1'b1, 4'h0, {24'h0, b});
    for (int i = 0; i < 3; i++) exp_op(1'b0, 4'h4, 32'h0);
    exp_op(1'b0, 4'h0, 32'h0);
  endtask

  task automatic drain();
    op_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m_op: got op adr %h we %b want no op", o.adr, o.we);
      end else begin
        e = exp_q.pop_front();
        chk("m_adr", o.adr, e.adr);
        chk("m_we",  {31'h0, o.we}, {31'h0, e.we});
        chk("m_dat", o.dat, e.dat);
        chk("m_sel", {28'h0, o.sel}, {28'h0, e.sel});
      end
    end
  endtask

  task automatic wait_cnt(input int target);
    for (int n = 0; n < 3000 && obs_cnt < target; n++) @(posedge clk);
    #1;
    chk("wait_cnt", obs_cnt, target);
  endtask

  task automatic wait_ops(input string name);
    irq_seen = 1'b0;
    for (int n = 0; n < 5000 && obs_cnt < exp_total; n++) begin
      @(posedge clk); #1;
      if (irq) irq_seen = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;
    chk(name, obs_cnt, exp_total);
    drain();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before 3ms");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] r;
    int          base;
    logic        found;

    s_bus.cyc = 1'b0; s_bus.stb = 1'b0; s_bus.we = 1'b0;
    s_bus.adr = '0;   s_bus.dat_w = '0; s_bus.sel = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ack", {31'h0, s_bus.ack}, 32'h0);
    chk("rst_s_dat", s_bus.dat_r, 32'h0);
    chk("rst_m_ctl", {29'h0, m_bus.cyc, m_bus.stb, m_bus.we}, 32'h0);
    chk("rst_m_adr", m_bus.adr, 32'h0);
    chk("rst_m_dat", m_bus.dat_w, 32'h0);
    chk("rst_irq",   {31'h0, irq}, 32'h0);
    reset = 1'b1;

    // 1: divisor then one byte
    exp_op(1'b1, 4'hC, 32'h3);
    exp_byte(8'h5A, 8'hA5);
    wr(4'hC, 32'h3);
    wr(4'h8, 32'h15A);
    wr(4'h0, 32'hA5);
    wait_ops("t1_ops");
    rd_chk("t1_status", 4'h4, 32'h0001_0004);
    rd_chk("t1_ctrl",   4'h8, 32'h0000_015A);
    rd_chk("t1_div",    4'hC, 32'h0000_0003);
    rd_chk("t1_rx",     4'h0, 32'h0000_003C);
    rd_chk("t1_status2", 4'h4, 32'h0000_0014);
    chk("t1_irq", {31'h0, irq}, 32'h0);

    // 2: four bytes in order, irq only once all are done
    wr(4'h8, 32'h05A);
    for (int i = 1; i <= 4; i++) begin
      wr(4'h0, i);
      exp_byte(8'h5A, 8'(i));
    end
    wr(4'h8, 32'h35A);
    wait_ops("t2_ops");
    chk("t2_irq_early", {31'h0, irq_seen}, 32'h0);
    chk("t2_irq", {31'h0, irq}, 32'h1);
    for (int i = 1; i <= 4; i++) rd_chk("t2_rx", 4'h0, {24'h0, 8'(i) ^ 8'h99});
    rd_chk("t2_status", 4'h4, 32'h0000_0014);
    wr(4'h8, 32'h05A);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_irq_off", {31'h0, irq}, 32'h0);

    // 3: TX fill with drop, then RX fill and overflow
    for (int i = 0; i < 17; i++) tbl.push_back(vec_t'{we: 1'b1, off: 4'h0, wd: 32'h10 + i, exp: 32'h0});
    tbl.push_back(vec_t'{we: 1'b0, off: 4'h4, wd: 32'h0, exp: 32'h0000_1012});
    tbl.push_back(vec_t'{we: 1'b0, off: 4'h8, wd: 32'h0, exp: 32'h0000_005A});
    tbl.push_back(vec_t'{we: 1'b0, off: 4'hC, wd: 32'h0, exp: 32'h0000_0003});
    tbl.push_back(vec_t'{we: 1'b0, off: 4'h0, wd: 32'h0, exp: 32'h0000_0000});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].off, tbl[i].wd);
      else begin
        cpu(1'b0, tbl[i].off, 32'h0, 0, r);
        chk($sformatf("vec%0d", i), r, tbl[i].exp);
      end
    end
    for (int i = 0; i < 16; i++) exp_byte(8'h5A, 8'h10 + 8'(i));
    wr(4'h8, 32'h15A);
    wait_ops("t3_ops");
    rd_chk("t3_rx_full", 4'h4, 32'h0010_000C);
    exp_byte(8'h5A, 8'h20);
    wr(4'h0, 32'h20);
    wait_ops("t3_ovf_ops");
    rd_chk("t3_ovf", 4'h4, 32'h0010_002C);
    wr(4'h4, 32'h20);
    rd_chk("t3_ovf_clr", 4'h4, 32'h0010_000C);
    for (int i = 0; i < 16; i++) rd_chk("t3_rx", 4'h0, {24'h0, (8'h10 + 8'(i)) ^ 8'h99});
    rd_chk("t3_status", 4'h4, 32'h0000_0014);

    // 4: disable mid-byte with three queued
    wr(4'h8, 32'h05A);
    wr(4'h0, 32'h41);
    wr(4'h0, 32'h42);
    wr(4'h0, 32'h43);
    base = obs_cnt;
    exp_byte(8'h5A, 8'h41);
    wr(4'h8, 32'h15A);
    wait_cnt(base + 3);
    wr(4'h8, 32'h05A);
    wait_ops("t4_ops");
    rd_chk("t4_status", 4'h4, 32'h0001_0200);
    rd_chk("t4_rx", 4'h0, 32'h0000_00D8);

    // 5: reset during DATA_WR
    exp_op(1'b1, 4'h8, 32'h5A);
    wr(4'h8, 32'h15A);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      found = m_bus.cyc && m_bus.we && (m_bus.adr == BASE);
    end
    chk("t5_data_wr", {31'h0, found}, 32'h1);
    chk("t5_data_val", m_bus.dat_w, 32'h42);
    reset = 1'b0;
    #1;
    chk("t5_cyc_stb", {30'h0, m_bus.cyc, m_bus.stb}, 32'h0);
    chk("t5_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ops("t5_ops");
    rd_chk("t5_status", 4'h4, 32'h0000_0014);
    rd_chk("t5_ctrl",   4'h8, 32'h0);
    rd_chk("t5_div",    4'hC, 32'h0);

    // 6: empty pop, held request, DIV mid-byte
    rd_chk("t6_rx_empty", 4'h0, 32'h0);
    rd_chk("t6_status", 4'h4, 32'h0000_0014);
    cpu(1'b1, 4'h0, 32'h61, 3, r);
    rd_chk("t6_once", 4'h4, 32'h0000_0110);
    wr(4'h0, 32'h62);
    base = obs_cnt;
    exp_byte(8'h5A, 8'h61);
    exp_op(1'b1, 4'hC, 32'h10);
    exp_byte(8'h5A, 8'h62);
    wr(4'h8, 32'h15A);
    wait_cnt(base + 3);
    wr(4'hC, 32'h10);
    wait_ops("t6_ops");
    rd_chk("t6_div", 4'hC, 32'h10);
    rd_chk("t6_rx0", 4'h0, 32'hF8);
    rd_chk("t6_rx1", 4'h0, 32'hFB);

    chk("exp_left", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
